rr_encoder_arbiter: RTL
=======================

Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Sits in front of the 8-to-3 priority encoder datapath and sequences it.
- Produces a registered one-hot grant plus its 3-bit encoded index.
- Supports grant hold until the requester releases, with an optional forced-rotation timeout.

Parameters:
- N, 8, number of requesters (fixed at 8 for this revision).
- IDX_W, 3, width of encoded grant index.
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held. 0 = unlimited.
- CNT_W, 5, width of hold counter. Must hold MAX_HOLD.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request vector, bit i = requester i. Level-sensitive.
- gnt  output  8  one-hot grant, registered. All zero when idle.
- gnt_idx  output  3  binary index of granted requester, registered.
- gnt_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset, sampled on clk rising edge with rst_n=0, sets:
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - ptr=0 (internal round-robin start pointer, 3 bits).
  - hold_cnt=0, state=IDLE.
- Reset overrides everything, including an active grant mid-operation.
- States: IDLE, GRANT.
- Winner selection (combinational): the first set bit of req scanning from ptr upward, wrapping 7->0. ptr itself is checked first.
- IDLE:
  - If req==0, stay in IDLE with outputs zero.
  - Otherwise, at the next edge go to GRANT: gnt=one-hot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req seen at edge t produces gnt visible after edge t+1 (one cycle).
- GRANT, release condition, evaluated each edge:
  - rel_drop = req[gnt_idx]==0.
  - rel_to = MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 and req[gnt_idx]==1.
  - Otherwise hold_cnt increments and the grant is unchanged.
- On release (rel_drop or rel_to):
  - Set ptr=gnt_idx+1 (mod 8), then choose a new winner in the same edge, searching from gnt_idx+1.
  - No bubble cycle: if the search finds a requester, gnt switches directly to it and hold_cnt=0.
  - If the search finds no requester, go to IDLE with gnt=0, gnt_valid=0. gnt_idx holds its last value.
- rel_to:
  - timeout=1 for exactly the cycle after the revoking edge.
  - The revoked requester is searched last. If it is the only requester, it is re-granted at once with hold_cnt=0: gnt unchanged, timeout still pulses.
- Grant duration:
  - Maximum is MAX_HOLD cycles.
  - Minimum is 1 cycle, if req drops immediately after the grant.
- Requests arriving or dropping on non-granted lines during GRANT have no effect until the next release.
- gnt is always one-hot or zero. gnt == (gnt_valid ? 1<<gnt_idx : 0) at every cycle.

Test Plan:
- Reset, then req=0 for 5 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout.
- Exclusive request, ptr=0: req=8'b00000100 at edge 1 -> after edge 2 gnt=8'b00000100, gnt_idx=2, gnt_valid=1. Drop req -> next edge gnt=0, gnt_valid=0, ptr=3.
- Simultaneous requests and wrap: after reset, req=8'b10000001 -> gnt_idx=0. Drop req[0] -> next edge gnt_idx=7, no bubble. Drop req[7] -> IDLE, ptr=0. Then req=8'b10000001 again -> gnt_idx=0.
- Timeout: MAX_HOLD=4, req[3] and req[5] held high.
  - gnt_idx=3 for exactly 4 cycles, then gnt_idx=5 with timeout=1 for one cycle.
  - After a further 4 cycles, gnt_idx returns to 3 with timeout pulsing again.
- Sole requester timeout: MAX_HOLD=4, only req[6] high -> gnt stays 8'b01000000 continuously, timeout pulses every 4 cycles.
- Reset mid-grant: gnt_idx=6 active, rst_n=0 for one edge -> all outputs zero next cycle. After release, the first grant with req=8'b11111111 is idx 0.
- Full fairness: MAX_HOLD=2, req=8'hFF held -> gnt_idx sequence 0,0,1,1,...,7,7,0,0.

Source files
------------

// File: rtl/rr_encoder_arbiter.sv
// rr_encoder_arbiter: 8-way round-robin arbiter with grant hold and forced-rotation timeout
module rr_encoder_arbiter #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);
    typedef enum logic {IDLE, GRANT} state_t;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);
    state_t           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d, ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] start, win_idx;
    logic             win_found, rel_drop, rel_to;
    // Search starts just past the current holder so the holder is considered last
    assign start    = (state_q == GRANT) ? gnt_idx_q + 1'b1 : ptr_q;
    assign rel_drop = (state_q == GRANT) && !req[gnt_idx_q];
    assign rel_to   = (state_q == GRANT) && (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && req[gnt_idx_q];
    // First set request at or after start, wrapping; scanned high-to-low so the nearest wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[start + IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = start + IDX_W'(k);
            end
        end
    end
    // Next-state: grant from idle, hold with counting, or release and hand over in the same edge
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            if (win_found) begin
                state_d        = GRANT;
                gnt_d          = '0;
                gnt_d[win_idx] = 1'b1;
                gnt_idx_d      = win_idx;
                hold_cnt_d     = '0;
            end
        end else if (rel_drop || rel_to) begin
            ptr_d      = gnt_idx_q + 1'b1;
            timeout_d  = rel_to;
            hold_cnt_d = '0;
            gnt_d      = '0;
            if (win_found) begin
                gnt_d[win_idx] = 1'b1;
                gnt_idx_d      = win_idx;
            end else begin
                state_d = IDLE;
            end
        end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end
    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = timeout_q;
endmodule
